// File: rtl/matrix_op_seq.sv
// Multi-cycle sequencer for matrix slice load/store and outer-product accumulate.
// Stalls the pipeline while it walks a row counter over the memory port or the MOPA unit.
`ifndef M_LD
  `define M_LD   3'b000
`endif
`ifndef M_ST
  `define M_ST   3'b001
`endif
`ifndef M_MOPA
  `define M_MOPA 3'b010
`endif
`ifndef M_MVTR
  `define M_MVTR 3'b011
`endif

module matrix_op_seq #(
  parameter int ROWS = 4,
  parameter int CW   = $clog2(ROWS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              issue_valid,
  input  logic [2:0]        issue_func3,
  input  logic [31:0]       issue_base,
  input  logic [1:0]        issue_md,
  input  logic [CW-1:0]     issue_slice,
  output logic              stall_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              mem_req,
  output logic              mem_we,
  output logic [31:0]       mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic              mem_gnt,
  input  logic [31:0]       mem_rdata,
  output logic [2+2*CW-1:0] mreg_raddr,
  input  logic [31:0]       mreg_rdata,
  output logic              mreg_we,
  output logic [2+2*CW-1:0] mreg_waddr,
  output logic [31:0]       mreg_wdata,
  output logic              mopa_en,
  output logic [CW-1:0]     mopa_row,
  output logic [1:0]        state_dbg
);

  // Handshake: a memory beat is in flight while mem_req is high; it completes in the
  // cycle mem_gnt is high (load data is taken from mem_rdata in that same cycle).
  // Address and store data are held constant until that cycle.

  typedef enum logic [1:0] {S_IDLE, S_LDST, S_MOPA, S_DONE} state_t;

  localparam logic [CW-1:0] LAST = CW'(ROWS - 1);

  state_t        state;
  logic [CW-1:0] cnt;
  logic          is_st;
  logic [1:0]    md;
  logic [CW-1:0] slice;
  logic [31:0]   base;
  logic          op_known;
  logic          accept;

  assign op_known = (issue_func3 == `M_LD) || (issue_func3 == `M_ST) ||
                    (issue_func3 == `M_MOPA);
  assign accept   = (state == S_IDLE) && issue_valid && op_known;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      cnt   <= '0;
      is_st <= 1'b0;
      md    <= '0;
      slice <= '0;
      base  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            md    <= issue_md;
            slice <= issue_slice;
            base  <= issue_base;
            is_st <= (issue_func3 == `M_ST);
            cnt   <= '0;
            state <= (issue_func3 == `M_MOPA) ? S_MOPA : S_LDST;
          end
        end
        S_LDST: begin
          if (mem_gnt) begin
            cnt <= cnt + CW'(1);
            if (cnt == LAST) state <= S_DONE;
          end
        end
        S_MOPA: begin
          cnt <= cnt + CW'(1);
          if (cnt == LAST) state <= S_DONE;
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Outputs decode directly from the registered state so the accept-cycle stall and
  // the same-cycle grant response carry no extra latency.
  always_comb begin
    stall_o    = accept;
    busy_o     = (state != S_IDLE);
    done_o     = 1'b0;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    mreg_raddr = '0;
    mreg_we    = 1'b0;
    mreg_waddr = '0;
    mreg_wdata = '0;
    mopa_en    = 1'b0;
    mopa_row   = '0;
    state_dbg  = state;
    case (state)
      S_LDST: begin
        stall_o    = 1'b1;
        mem_req    = 1'b1;
        mem_we     = is_st;
        mem_addr   = base + 32'({cnt, 2'b00});
        mreg_raddr = {md, slice, cnt};
        mem_wdata  = mreg_rdata;
        if (!is_st) begin
          mreg_we    = mem_gnt;
          mreg_waddr = {md, slice, cnt};
          mreg_wdata = mem_rdata;
        end
      end
      S_MOPA: begin
        stall_o  = 1'b1;
        mopa_en  = 1'b1;
        mopa_row = cnt;
      end
      S_DONE:  done_o = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_matrix_op_seq.sv
// Bench for matrix_op_seq: directed scenarios plus randomized ops against a
// transaction-level model (beat index = grants seen, address = base + 4*beat).
`ifndef M_LD
  `define M_LD   3'b000
`endif
`ifndef M_ST
  `define M_ST   3'b001
`endif
`ifndef M_MOPA
  `define M_MOPA 3'b010
`endif
`ifndef M_MVTR
  `define M_MVTR 3'b011
`endif

module tb_matrix_op_seq;
  localparam int ROWS = 4;
  localparam int CW   = 2;
  localparam int AW   = 2 + 2 * CW;

  logic          clk = 1'b0;
  logic          rst;
  logic          issue_valid;
  logic [2:0]    issue_func3;
  logic [31:0]   issue_base;
  logic [1:0]    issue_md;
  logic [CW-1:0] issue_slice;
  logic          stall_o, busy_o, done_o, mem_req, mem_we, mem_gnt;
  logic [31:0]   mem_addr, mem_wdata, mem_rdata;
  logic [AW-1:0] mreg_raddr, mreg_waddr;
  logic [31:0]   mreg_rdata, mreg_wdata;
  logic          mreg_we, mopa_en;
  logic [CW-1:0] mopa_row;
  logic [1:0]    state_dbg;
  logic [116:0]  outs_v;

  int n_pass = 0;
  int n_checks = 0;

  logic [31:0] mfile [0:(1<<AW)-1];
  logic [AW+31:0] exp_q[$];

  matrix_op_seq #(.ROWS(ROWS), .CW(CW)) dut (
    .clk(clk), .rst(rst), .issue_valid(issue_valid), .issue_func3(issue_func3),
    .issue_base(issue_base), .issue_md(issue_md), .issue_slice(issue_slice),
    .stall_o(stall_o), .busy_o(busy_o), .done_o(done_o), .mem_req(mem_req),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_gnt(mem_gnt),
    .mem_rdata(mem_rdata), .mreg_raddr(mreg_raddr), .mreg_rdata(mreg_rdata),
    .mreg_we(mreg_we), .mreg_waddr(mreg_waddr), .mreg_wdata(mreg_wdata),
    .mopa_en(mopa_en), .mopa_row(mopa_row), .state_dbg(state_dbg)
  );

  // clock / reset block
  always #5 clk = ~clk;

  assign outs_v = {stall_o, busy_o, done_o, mem_req, mem_we, mem_addr, mem_wdata,
                   mreg_raddr, mreg_we, mreg_waddr, mreg_wdata, mopa_en, mopa_row};

  // behavioural matrix register file
  assign mreg_rdata = mfile[mreg_raddr];
  always @(posedge clk) if (mreg_we) mfile[mreg_waddr] <= mreg_wdata;

  function automatic logic [AW-1:0] maddr(input int md, input int sl, input int w);
    return AW'(md * 16 + sl * 4 + w);
  endfunction

  // driver tasks
  task automatic issue(input logic [2:0] f, input logic [31:0] b, input logic [1:0] m,
                       input logic [CW-1:0] s);
    issue_valid = 1'b1; issue_func3 = f; issue_base = b; issue_md = m; issue_slice = s;
  endtask

  task automatic idle_inputs();
    issue_valid = 1'b0; issue_func3 = 3'b000; issue_base = '0; issue_md = '0;
    issue_slice = '0; mem_gnt = 1'b0; mem_rdata = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1; idle_inputs();
    repeat (3) @(negedge clk);
    rst = 1'b0; #1;
    n_checks++; if (outs_v !== '0) $display("FAIL reset_outs: got %h want 0", outs_v); else n_pass++;
  endtask

  task automatic test_load_basic();
    @(negedge clk); issue(`M_LD, 32'h100, 2'd2, 2'd1); mem_gnt = 1'b1; #1;
    n_checks++; if (stall_o !== 1'b1) $display("FAIL ld_accept_stall: got %b want 1", stall_o); else n_pass++;
    @(negedge clk); issue_valid = 1'b0;
    for (int i = 0; i < ROWS; i++) begin
      mem_rdata = 32'hA0 + i; #1;
      n_checks++; if (mem_addr !== 32'h100 + 4 * i) $display("FAIL ld_addr[%0d]: got %h want %h", i, mem_addr, 32'h100 + 4 * i); else n_pass++;
      n_checks++; if ({stall_o, mreg_we, mreg_waddr, mreg_wdata} !== {1'b1, 1'b1, maddr(2, 1, i), 32'hA0 + i})
        $display("FAIL ld_write[%0d]: got %b %b %h %h", i, stall_o, mreg_we, mreg_waddr, mreg_wdata); else n_pass++;
      @(negedge clk);
    end
    #1;
    n_checks++; if ({done_o, stall_o} !== 2'b10) $display("FAIL ld_done: got done=%b stall=%b want 1 0", done_o, stall_o); else n_pass++;
    @(negedge clk); #1;
    n_checks++; if ({busy_o, done_o} !== 2'b00) $display("FAIL ld_idle: got busy=%b done=%b want 0 0", busy_o, done_o); else n_pass++;
    for (int i = 0; i < ROWS; i++) begin
      n_checks++; if (mfile[maddr(2, 1, i)] !== 32'hA0 + i) $display("FAIL ld_file[%0d]: got %h want %h", i, mfile[maddr(2, 1, i)], 32'hA0 + i); else n_pass++;
    end
    mem_gnt = 1'b0;
  endtask

  task automatic test_store_stall();
    logic [31:0] sd [0:3];
    logic gp [0:5];
    int beat;
    gp = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    for (int i = 0; i < ROWS; i++) begin
      sd[i] = $urandom; mfile[maddr(1, 3, i)] = sd[i];
    end
    @(negedge clk); issue(`M_ST, 32'h200, 2'd1, 2'd3); #1;
    @(negedge clk); issue_valid = 1'b0;
    beat = 0;
    for (int c = 1; c <= 6; c++) begin
      mem_gnt = gp[c-1]; #1;
      n_checks++; if ({mem_req, mem_we, mem_addr} !== {2'b11, 32'h200 + 4 * beat})
        $display("FAIL st_addr cyc%0d: got %b%b %h want 11 %h", c, mem_req, mem_we, mem_addr, 32'h200 + 4 * beat); else n_pass++;
      n_checks++; if ({mreg_we, mem_wdata} !== {1'b0, sd[beat]})
        $display("FAIL st_data cyc%0d: got we=%b %h want 0 %h", c, mreg_we, mem_wdata, sd[beat]); else n_pass++;
      if (mem_gnt) beat++;
      @(negedge clk);
    end
    mem_gnt = 1'b0; #1;
    n_checks++; if (done_o !== 1'b1) $display("FAIL st_done_cyc7: got %b want 1", done_o); else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_mopa_back_to_back();
    @(negedge clk); issue(`M_MOPA, 32'h0, 2'd0, 2'd0);
    for (int rep = 0; rep < 2; rep++) begin
      #1;
      n_checks++; if ({stall_o, busy_o} !== 2'b10) $display("FAIL mopa_accept%0d: got stall=%b busy=%b want 1 0", rep, stall_o, busy_o); else n_pass++;
      @(negedge clk);
      for (int r = 0; r < ROWS; r++) begin
        #1;
        n_checks++; if ({mopa_en, mopa_row, mem_req, stall_o} !== {1'b1, CW'(r), 1'b0, 1'b1})
          $display("FAIL mopa_row%0d_%0d: got en=%b row=%0d req=%b stall=%b", rep, r, mopa_en, mopa_row, mem_req, stall_o); else n_pass++;
        @(negedge clk);
      end
      #1;
      n_checks++; if ({done_o, stall_o} !== 2'b10) $display("FAIL mopa_done%0d: got done=%b stall=%b want 1 0", rep, done_o, stall_o); else n_pass++;
      @(negedge clk);
    end
    issue_valid = 1'b0; #1;
    n_checks++; if ({busy_o, stall_o} !== 2'b00) $display("FAIL mopa_end_idle: got busy=%b stall=%b", busy_o, stall_o); else n_pass++;
  endtask

  task automatic test_ignored();
    logic [2:0] fs [0:1];
    fs = '{`M_MVTR, 3'b111};
    for (int k = 0; k < 2; k++) begin
      @(negedge clk); issue(fs[k], 32'h123, 2'd1, 2'd2);
      for (int c = 0; c < 3; c++) begin
        #1;
        n_checks++; if (outs_v !== '0) $display("FAIL ignored_f%0d_c%0d: got %h want 0", fs[k], c, outs_v); else n_pass++;
        @(negedge clk);
      end
      issue_valid = 1'b0;
    end
  endtask

  task automatic test_addr_wrap();
    logic [31:0] ea [0:3];
    ea = '{32'hFFFFFFF8, 32'hFFFFFFFC, 32'h00000000, 32'h00000004};
    @(negedge clk); issue(`M_LD, 32'hFFFFFFF8, 2'd0, 2'd2); mem_gnt = 1'b1;
    @(negedge clk); issue_valid = 1'b0;
    for (int i = 0; i < ROWS; i++) begin
      mem_rdata = $urandom; #1;
      n_checks++; if (mem_addr !== ea[i]) $display("FAIL wrap_addr[%0d]: got %h want %h", i, mem_addr, ea[i]); else n_pass++;
      @(negedge clk);
    end
    #1;
    n_checks++; if (done_o !== 1'b1) $display("FAIL wrap_done: got %b want 1", done_o); else n_pass++;
    mem_gnt = 1'b0; @(negedge clk);
  endtask

  task automatic test_reset_mid_op();
    @(negedge clk); issue(`M_LD, 32'h300, 2'd3, 2'd0); mem_gnt = 1'b1;
    @(negedge clk); issue_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk); rst = 1'b0; mem_gnt = 1'b0; #1;
    n_checks++; if (outs_v !== '0) $display("FAIL rst_mid_outs: got %h want 0", outs_v); else n_pass++;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk); #1;
      n_checks++; if ({done_o, busy_o} !== 2'b00) $display("FAIL rst_mid_nodone%0d: got done=%b busy=%b", c, done_o, busy_o); else n_pass++;
    end
    @(negedge clk); issue(`M_LD, 32'h400, 2'd3, 2'd0); mem_gnt = 1'b1;
    @(negedge clk); issue_valid = 1'b0; #1;
    n_checks++; if ({mem_addr, mreg_waddr} !== {32'h400, maddr(3, 0, 0)})
      $display("FAIL rst_mid_restart: got %h %h want 400 %h", mem_addr, mreg_waddr, maddr(3, 0, 0)); else n_pass++;
    repeat (ROWS) @(negedge clk);
    #1;
    n_checks++; if (done_o !== 1'b1) $display("FAIL rst_mid_restart_done: got %b want 1", done_o); else n_pass++;
    mem_gnt = 1'b0; @(negedge clk);
  endtask

  task automatic test_random_ops();
    logic [2:0] f;
    logic [31:0] b;
    logic [1:0] m;
    logic [CW-1:0] s;
    logic [AW+31:0] e;
    int beats, cyc, kind;
    bit fin;
    for (int n = 0; n < 30; n++) begin
      kind = $urandom_range(0, 3);
      f = (kind == 0) ? `M_LD : (kind == 1) ? `M_ST : (kind == 2) ? `M_MOPA : 3'b100 + 3'($urandom_range(0, 3));
      if (kind == 3 && $urandom_range(0, 1) == 1) f = `M_MVTR;
      b = $urandom; m = 2'($urandom); s = CW'($urandom);
      @(negedge clk); issue(f, b, m, s); mem_gnt = 1'b0; #1;
      n_checks++; if (stall_o !== (kind != 3)) $display("FAIL rnd%0d_accept: got %b want %b", n, stall_o, kind != 3); else n_pass++;
      @(negedge clk); issue_valid = 1'b0;
      if (kind == 3) begin
        #1;
        n_checks++; if (busy_o !== 1'b0) $display("FAIL rnd%0d_ignored_busy: got %b want 0", n, busy_o); else n_pass++;
        continue;
      end
      beats = 0; cyc = 0; fin = 0;
      while (!fin) begin
        mem_gnt = (kind != 2) && ($urandom_range(0, 2) != 0);
        mem_rdata = $urandom; #1;
        if ((kind == 2 && cyc == ROWS) || (kind != 2 && beats == ROWS)) begin
          n_checks++; if ({done_o, stall_o} !== 2'b10) $display("FAIL rnd%0d_done: got done=%b stall=%b want 1 0", n, done_o, stall_o); else n_pass++;
          fin = 1;
        end else if (kind == 2) begin
          n_checks++; if ({done_o, mopa_en, mopa_row, mem_req} !== {1'b0, 1'b1, CW'(cyc), 1'b0})
            $display("FAIL rnd%0d_mopa%0d: got done=%b en=%b row=%0d req=%b", n, cyc, done_o, mopa_en, mopa_row, mem_req); else n_pass++;
        end else begin
          n_checks++; if ({done_o, mem_req, mem_we, mem_addr, mreg_raddr} !== {1'b0, 1'b1, kind == 1, b + 32'(4 * beats), maddr(m, s, beats)})
            $display("FAIL rnd%0d_beat%0d: got done=%b req=%b we=%b addr=%h ra=%h want addr=%h", n, beats, done_o, mem_req, mem_we, mem_addr, mreg_raddr, b + 32'(4 * beats)); else n_pass++;
          n_checks++; if (mreg_we !== (kind == 0 && mem_gnt)) $display("FAIL rnd%0d_mreg_we%0d: got %b", n, beats, mreg_we); else n_pass++;
          if (mem_gnt) begin
            if (kind == 0) exp_q.push_back({maddr(m, s, beats), mem_rdata});
            beats++;
          end
        end
        cyc++;
        @(negedge clk);
        if (cyc > 200) begin
          n_checks++; $display("FAIL rnd%0d_timeout: no done after %0d cycles", n, cyc);
          fin = 1;
        end
      end
      mem_gnt = 1'b0;
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_checks++; if (mfile[e[AW+31:32]] !== e[31:0]) $display("FAIL rnd%0d_file[%h]: got %h want %h", n, e[AW+31:32], mfile[e[AW+31:32]], e[31:0]); else n_pass++;
      end
    end
  endtask

  initial begin
    for (int i = 0; i < (1 << AW); i++) mfile[i] = '0;
    test_reset();
    test_load_basic();
    test_store_stall();
    test_mopa_back_to_back();
    test_ignored();
    test_addr_wrap();
    test_reset_mid_op();
    test_random_ops();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule

// File: doc/matrix_op_seq.md
Name: matrix_op_seq

Overview:
Multi-cycle sequencer for matrix instructions that cannot finish in one EX cycle: slice load (M_LD), slice store (M_ST) and outer-product accumulate (M_MOPA). It sits beside EX, after decode has classified an Mtype instruction. It stalls the pipeline, walks a word/row counter, drives the 32-bit data memory port with a req/gnt handshake and drives the matrix register file write port. M_MVTR and every other func3 are single-cycle ops handled elsewhere and are ignored here.

Parameters:
ROWS, 4, rows per matrix = 32-bit words per slice; power of two, at least 2
CW, $clog2(ROWS), width of the row/word counter

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
issue_valid  in  1  an Mtype instruction is in EX
issue_func3  in  3  inst_func3_code of that instruction (`M_LD/`M_ST/`M_MOPA)
issue_base  in  32  byte base address (rs1+imm) for LD/ST
issue_md  in  2  matrix register index
issue_slice  in  CW  slice (row) index for LD/ST
stall_o  out  1  hold IF/ID/EX
busy_o  out  1  state is not IDLE
done_o  out  1  one-cycle pulse when the operation completes
mem_req  out  1  memory beat request
mem_we  out  1  1 = store beat
mem_addr  out  32  beat byte address
mem_wdata  out  32  store data
mem_gnt  in  1  beat accepted; for loads mem_rdata is valid in the same cycle
mem_rdata  in  32  load data
mreg_raddr  out  2+2*CW  {md, slice, word} read address of the matrix file
mreg_rdata  in  32  combinational read data
mreg_we  out  1  write one word of the matrix file
mreg_waddr  out  2+2*CW  {md, slice, word}
mreg_wdata  out  32  write data
mopa_en  out  1  outer-product unit: accumulate one row this cycle
mopa_row  out  CW  row being accumulated

Behaviour:
- States: IDLE, LDST, MOPA, DONE. Registers: state, cnt[CW-1:0], is_st, md, slice, base.
- Accept: in IDLE with issue_valid and func3 in {`M_LD, `M_ST, `M_MOPA}. On accept, latch md/slice/base, set is_st = (func3==`M_ST), clear cnt. Next state is LDST for LD/ST and MOPA for MOPA. Any other func3, or issue_valid low, leaves IDLE unchanged with no stall.
- stall_o is combinational: 1 in the accept cycle and throughout LDST and MOPA; 0 in IDLE and DONE. In DONE the pipeline advances past the instruction.
- LDST:
  - mem_req=1, mem_we=is_st, mem_addr=base+{cnt,2'b00}, computed mod 2^32 with no trap on wrap.
  - mreg_raddr={md,slice,cnt}; mem_wdata=mreg_rdata.
  - Load: mreg_we=mem_gnt, mreg_waddr={md,slice,cnt}, mreg_wdata=mem_rdata.
  - mem_req stays high until gnt. Address and data are stable while gnt is low.
  - On gnt, cnt increments. If cnt==ROWS-1 and gnt, go to DONE.
- MOPA: mopa_en=1, mopa_row=cnt. cnt increments every cycle. After row ROWS-1, go to DONE. The accumulate unit owns the actual matrix writes.
- DONE: done_o=1 for exactly one cycle, then IDLE. issue_valid is ignored in DONE; a back-to-back op is accepted no earlier than the following IDLE cycle.
- Latency from the accept cycle to the done_o cycle:
  - MOPA: ROWS+1 cycles.
  - LD/ST: (sum of the beat cycles) + 1, which is ROWS+1 with gnt always high.
- Outputs not listed for a state are 0. In IDLE all outputs are 0, except stall_o in the accept cycle.
- Reset, including mid-operation: state=IDLE, cnt=0, all latched fields 0, every output 0 in the cycle after rst. No done_o pulse is produced for the aborted op, and a partially written slice is left as is.

Test Plan:
- ROWS=4, `M_LD, base=0x100, md=2, slice=1, gnt always 1, rdata=0xA0..0xA3 -> addrs 0x100,0x104,0x108,0x10C in 4 consecutive cycles; mreg writes to {2,1,0..3}; done_o in cycle 5; stall_o high cycles 0-4.
- `M_ST, base=0x200, gnt low for 2 cycles on beat 1 -> mem_addr holds 0x204 and mem_wdata holds mreg[{md,slice,1}] while gnt is low; done_o at cycle 7; mreg_we never asserted.
- `M_MOPA -> mopa_en high for 4 cycles with mopa_row 0,1,2,3; no mem_req; done_o on the 5th cycle; back-to-back MOPA with issue_valid held is accepted in the cycle after DONE.
- `M_MVTR and func3=3'b111 with issue_valid=1 -> stall_o=0, busy_o=0, all outputs 0.
- Load with base=0xFFFFFFF8 -> addrs 0xFFFFFFF8, 0xFFFFFFFC, 0x00000000, 0x00000004.
- rst asserted during LDST beat 2 -> next cycle: IDLE, all outputs 0, no done_o; a new `M_LD afterwards starts at word 0.
